// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and defaults for the RV32 pipeline stages
package riscv_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLTU  = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;
  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_cond_e;
endpackage

// File: rtl/ex_if.sv
// ex_if: Execute-stage bundle (ID/EX fields, writeback forward, redirect, EX/MEM fields)
interface ex_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] RD1_E, RD2_E, PC_E, PCPlus4_E, ExtImm_E;
  logic [4:0]      Rs1_E, Rs2_E, Rd_E;
  logic            ALUSrc_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, JumpR_E;
  logic [1:0]      ResultSrc_E;
  logic [2:0]      ALUControl_E;
  logic [1:0]      BrCond_E;
  logic            RegWrite_W;
  logic [4:0]      Rd_W;
  logic [XLEN-1:0] Result_W;
  logic            PCSrc_E;
  logic [XLEN-1:0] PCTarget_E;
  logic [XLEN-1:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]      Rd_M;
  logic            RegWrite_M, MemWrite_M;
  logic [1:0]      ResultSrc_M;
  modport master (
    output RD1_E, RD2_E, PC_E, PCPlus4_E, ExtImm_E, Rs1_E, Rs2_E, Rd_E,
           ALUSrc_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, JumpR_E,
           ResultSrc_E, ALUControl_E, BrCond_E, RegWrite_W, Rd_W, Result_W,
    input  PCSrc_E, PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M,
           RegWrite_M, MemWrite_M, ResultSrc_M
  );
  modport slave (
    input  RD1_E, RD2_E, PC_E, PCPlus4_E, ExtImm_E, Rs1_E, Rs2_E, Rd_E,
           ALUSrc_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, JumpR_E,
           ResultSrc_E, ALUControl_E, BrCond_E, RegWrite_W, Rd_W, Result_W,
    output PCSrc_E, PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M,
           RegWrite_M, MemWrite_M, ResultSrc_M
  );
endinterface

// File: rtl/alu.sv
// alu: combinational RV32 ALU with zero flag
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);
  logic w_slt, w_sltu;
  // opcode select; compares zero-extend to full width
  always_comb begin
    w_slt     = $signed(SrcA) < $signed(SrcB);
    w_sltu    = SrcA < SrcB;
    ALUResult = (ALUControl == ALU_ADD)  ? SrcA + SrcB :
                (ALUControl == ALU_SUB)  ? SrcA - SrcB :
                (ALUControl == ALU_AND)  ? SrcA & SrcB :
                (ALUControl == ALU_OR)   ? SrcA | SrcB :
                (ALUControl == ALU_XOR)  ? SrcA ^ SrcB :
                (ALUControl == ALU_SLT)  ? {{(XLEN-1){1'b0}}, w_slt} :
                (ALUControl == ALU_SLTU) ? {{(XLEN-1){1'b0}}, w_sltu} : SrcB;
    Zero      = ALUResult == '0;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with M/W forwarding, branch resolution and EX/MEM register
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  localparam logic [XLEN-1:0] PC4_RST = RESET_PC_ZERO ? {XLEN{1'b0}} : XLEN'(4);
  logic [XLEN-1:0] r_alu, r_wd, r_pc4;
  logic [4:0]      r_rd;
  logic            r_rw, r_mw;
  logic [1:0]      r_rsrc;
  logic [XLEN-1:0] w_fwd_m, w_src_a, w_fwd_b, w_src_b, w_alu;
  logic            w_zero, w_cond;
  // operand forwarding: Memory beats Writeback, x0 never forwarded
  always_comb begin
    w_fwd_m = (r_rsrc == RES_PC4) ? r_pc4 : r_alu;
    w_src_a = (r_rw && r_rd == bus.Rs1_E && bus.Rs1_E != 5'd0) ? w_fwd_m :
              (bus.RegWrite_W && bus.Rd_W == bus.Rs1_E && bus.Rs1_E != 5'd0) ? bus.Result_W : bus.RD1_E;
    w_fwd_b = (r_rw && r_rd == bus.Rs2_E && bus.Rs2_E != 5'd0) ? w_fwd_m :
              (bus.RegWrite_W && bus.Rd_W == bus.Rs2_E && bus.Rs2_E != 5'd0) ? bus.Result_W : bus.RD2_E;
    w_src_b = bus.ALUSrc_E ? bus.ExtImm_E : w_fwd_b;
  end
  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (w_src_a),
    .SrcB       (w_src_b),
    .ALUControl (bus.ALUControl_E),
    .ALUResult  (w_alu),
    .Zero       (w_zero)
  );
  // branch condition and same-cycle redirect; jalr target clears bit 0
  always_comb begin
    w_cond         = (bus.BrCond_E == BR_EQ) ? w_zero :
                     (bus.BrCond_E == BR_NE) ? !w_zero :
                     (bus.BrCond_E == BR_LT) ? w_alu[0] : !w_alu[0];
    bus.PCSrc_E    = bus.Jump_E | bus.JumpR_E | (bus.Branch_E & w_cond);
    bus.PCTarget_E = bus.JumpR_E ? ((w_src_a + bus.ExtImm_E) & ~XLEN'(1)) : (bus.PC_E + bus.ExtImm_E);
  end
  // EX/MEM register: captures every edge, reset drops the in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu  <= '0;
      r_wd   <= '0;
      r_pc4  <= PC4_RST;
      r_rd   <= '0;
      r_rw   <= 1'b0;
      r_mw   <= 1'b0;
      r_rsrc <= '0;
    end else begin
      r_alu  <= w_alu;
      r_wd   <= w_fwd_b;
      r_pc4  <= bus.PCPlus4_E;
      r_rd   <= bus.Rd_E;
      r_rw   <= bus.RegWrite_E;
      r_mw   <= bus.MemWrite_E;
      r_rsrc <= bus.ResultSrc_E;
    end
  end
  assign bus.ALUResult_M = r_alu;
  assign bus.WriteData_M = r_wd;
  assign bus.PCPlus4_M   = r_pc4;
  assign bus.Rd_M        = r_rd;
  assign bus.RegWrite_M  = r_rw;
  assign bus.MemWrite_M  = r_mw;
  assign bus.ResultSrc_M = r_rsrc;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32 pipeline, placed directly downstream of the ID/EX pipeline register. It consumes the decoded Execute-stage fields and applies operand forwarding from Memory and Writeback. It performs the ALU operation and resolves branches and jumps, producing the redirect to Fetch in the same cycle. Results are registered into the EX/MEM pipeline register held inside the block.

## Interface
Parameters:
- XLEN, 32, datapath width
- RESET_PC_ZERO, 1, EX/MEM PC-related fields reset to 0

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- RD1_E, RD2_E  in  XLEN  register-file operands
- PC_E, PCPlus4_E, ExtImm_E  in  XLEN  PC, PC+4, extended immediate
- Rs1_E, Rs2_E, Rd_E  in  5  register indices
- ALUSrc_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, JumpR_E  in  1  control
- ResultSrc_E  in  2  00 ALU, 01 memory, 10 PC+4
- ALUControl_E  in  3  ALU opcode
- BrCond_E  in  2  00 beq, 01 bne, 10 blt, 11 bge
- RegWrite_W  in  1, Rd_W  in  5, Result_W  in  XLEN  writeback forwarding source
- PCSrc_E  out  1  redirect Fetch this cycle
- PCTarget_E  out  XLEN  redirect address
- ALUResult_M, WriteData_M, PCPlus4_M  out  XLEN  EX/MEM data
- Rd_M  out  5, RegWrite_M, MemWrite_M  out  1, ResultSrc_M  out  2  EX/MEM fields

## Operation
- Forwarding, evaluated separately for SrcA (Rs1_E) and ForwardedB (Rs2_E):
  - Memory stage wins when RegWrite_M, Rd_M == Rs, and Rs != 0. The forwarded value is PCPlus4_M if ResultSrc_M == 10, otherwise ALUResult_M.
  - Otherwise Writeback is used when RegWrite_W, Rd_W == Rs, and Rs != 0, forwarding Result_W.
  - Otherwise the register-file operand is used.
  - x0 is never forwarded.
- SrcB = ALUSrc_E ? ExtImm_E : ForwardedB. WriteData_M captures ForwardedB, never the immediate.
- ALU opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed; result is 0 or 1, zero-extended)
  - 110 SLTU
  - 111 pass SrcB (lui)
- Arithmetic is modulo 2^XLEN with no overflow flag. Zero = (ALUResult == 0).
- Branch condition:
  - beq: Zero
  - bne: !Zero
  - blt: ALUResult[0], with the decoder issuing SLT
  - bge: !ALUResult[0]
- PCSrc_E = Jump_E | JumpR_E | (Branch_E & cond).
- PCTarget_E = JumpR_E ? ((SrcA + ExtImm_E) & ~1) : (PC_E + ExtImm_E). It is computed regardless of PCSrc_E.
- Load-use stalls are not handled here. The hazard unit clears ID/EX, which presents a bubble (all controls 0) to this block.

## Timing
- PCSrc_E and PCTarget_E are combinational from the E inputs and the current M/W state, valid in the same cycle.
- The EX/MEM register has a latency of 1 cycle. It captures every rising edge, with no enable and no clear.
- Reset: while rst is low, every M output is 0 (ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M). Reset is asserted immediately and asynchronously.
- Reset mid-operation discards the in-flight instruction. No memory write or register write is issued from a reset state.
- Bubble input (all controls 0, Rd_E = 0) must produce RegWrite_M = MemWrite_M = 0 next cycle.
- Simultaneous M and W match on the same Rs: M takes priority.
- Branch in E while a taken jump is in M: no interaction. Flushing younger stages is the hazard unit's job, driven from PCSrc_E.

## Structure
- Shared package `riscv_pkg`:
  - ALU opcode constants (ALU_ADD..ALU_PASSB)
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4)
  - BrCond encodings
  - XLEN default
- Sub-module `alu`: combinational, with ports SrcA, SrcB, ALUControl in, ALUResult and Zero out. It is reused by the unit-level ALU bench.
- Forwarding muxes, branch logic and the EX/MEM register are inlined in `ex_stage`.

## Test plan
- Reset: rst low mid-stream with RegWrite_E = 1 -> all M outputs read 0 during reset and on the first edge after release, until new input is captured.
- Forward priority: Rs1_E = 5, M holds Rd = 5 / ALUResult 0x10, W holds Rd = 5 / Result 0x20, ADD with imm 1 -> ALUResult_M = 0x11. Repeat with Rs1_E = 0 and RD1_E = 0 -> 0x1.
- Jal forward: M has ResultSrc 10, Rd 3, PCPlus4_M 0x104; Rs2_E = 3, SUB with RD1 0x200 -> ALUResult_M = 0xFC.
- Branches: SUB on RD1 = RD2 = 7 with beq, Branch_E = 1, PC 0x40, imm 0x20 -> PCSrc_E = 1, PCTarget_E = 0x60. Same operands with bne -> PCSrc_E = 0. SLT on -1 vs 1 with blt -> taken.
- Jalr: JumpR_E = 1, SrcA 0x1003, imm 0x4 -> PCTarget_E = 0x1006, PCSrc_E = 1.
- Store data: ALUSrc_E = 1, MemWrite_E = 1, Rs2_E forwarded from W with value 0xDEADBEEF -> WriteData_M = 0xDEADBEEF and MemWrite_M = 1 one cycle later.
